// File: rtl/banco_registros_param.sv
// Two-read/one-write register bank: registered reads (1-cycle latency), optional x0 hardwiring and write-to-read forwarding.
// Rd_En=0 stalls both read outputs while writes continue; async active-low reset clears array and outputs.
module banco_registros_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Rd_En,
  input  logic [ADDR_W-1:0] Add_A,
  input  logic [ADDR_W-1:0] Add_B,
  input  logic [ADDR_W-1:0] Add_Dest,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Write_En,
  output logic [DATA_W-1:0] Info_A,
  output logic [DATA_W-1:0] Info_B
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign wr_ok = Write_En && !((ZERO_REG != 0) && (Add_Dest == '0));

  // Precedence per port: hardwired zero, then forwarded write data, then stored value.
  always_comb begin
    rd_a = regs[Add_A];
    if ((BYPASS != 0) && Write_En && (Add_Dest == Add_A)) rd_a = Write_Data;
    if ((ZERO_REG != 0) && (Add_A == '0)) rd_a = '0;
  end

  always_comb begin
    rd_b = regs[Add_B];
    if ((BYPASS != 0) && Write_En && (Add_Dest == Add_B)) rd_b = Write_Data;
    if ((ZERO_REG != 0) && (Add_B == '0)) rd_b = '0;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[Add_Dest] <= Write_Data;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Info_A <= '0;
      Info_B <= '0;
    end else if (Rd_En) begin
      Info_A <= rd_a;
      Info_B <= rd_b;
    end
  end

endmodule

// File: tb/tb_banco_registros_param.sv
// Randomised + directed bench for banco_registros_param across three parameter sets,
// compared against a per-instance array model evaluated once per clock edge.
module tb_banco_registros_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic        wr_en;
  logic [4:0]  add_a, add_b, add_d;
  logic [63:0] wdata;

  logic [31:0] ia0, ib0, ia1, ib1;
  logic [63:0] ia2, ib2;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance k parameter sets: {DATA_W, ADDR_W, ZERO_REG, BYPASS}
  int dw_p [3] = '{32, 32, 64};
  int aw_p [3] = '{5, 5, 4};
  int zr_p [3] = '{1, 0, 1};
  int bp_p [3] = '{1, 0, 1};

  logic [63:0] mreg [3][32];
  logic [63:0] m_a  [3];
  logic [63:0] m_b  [3];

  always #5 clk = ~clk;

  banco_registros_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_d0 (
    .CLK(clk), .RST_n(rst_n), .Rd_En(rd_en), .Add_A(add_a), .Add_B(add_b),
    .Add_Dest(add_d), .Write_Data(wdata[31:0]), .Write_En(wr_en), .Info_A(ia0), .Info_B(ib0));

  banco_registros_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_d1 (
    .CLK(clk), .RST_n(rst_n), .Rd_En(rd_en), .Add_A(add_a), .Add_B(add_b),
    .Add_Dest(add_d), .Write_Data(wdata[31:0]), .Write_En(wr_en), .Info_A(ia1), .Info_B(ib1));

  banco_registros_param #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_d2 (
    .CLK(clk), .RST_n(rst_n), .Rd_En(rd_en), .Add_A(add_a[3:0]), .Add_B(add_b[3:0]),
    .Add_Dest(add_d[3:0]), .Write_Data(wdata), .Write_En(wr_en), .Info_A(ia2), .Info_B(ib2));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dmask(input int k);
    return (dw_p[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw_p[k]) - 64'd1);
  endfunction

  function automatic logic [4:0] amask(input int k, input logic [4:0] a);
    return (aw_p[k] == 5) ? a : (a & 5'h0F);
  endfunction

  // What a read of register x returns on the coming edge for instance k.
  function automatic logic [63:0] mval(input int k, input logic [4:0] x);
    if (zr_p[k] != 0 && x == 5'd0) return 64'd0;
    if (bp_p[k] != 0 && wr_en && amask(k, add_d) == x) return wdata & dmask(k);
    return mreg[k][x];
  endfunction

  task automatic model_edge();
    logic [63:0] va, vb;
    logic [4:0]  d;
    for (int k = 0; k < 3; k++) begin
      va = mval(k, amask(k, add_a));
      vb = mval(k, amask(k, add_b));
      if (rd_en) begin
        m_a[k] = va;
        m_b[k] = vb;
      end
      d = amask(k, add_d);
      if (wr_en && !(zr_p[k] != 0 && d == 5'd0)) mreg[k][d] = wdata & dmask(k);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 32; r++) mreg[k][r] = 64'd0;
      m_a[k] = 64'd0;
      m_b[k] = 64'd0;
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".a0"}, {32'd0, ia0}, m_a[0]);
    check_val({tag, ".b0"}, {32'd0, ib0}, m_b[0]);
    check_val({tag, ".a1"}, {32'd0, ia1}, m_a[1]);
    check_val({tag, ".b1"}, {32'd0, ib1}, m_b[1]);
    check_val({tag, ".a2"}, ia2, m_a[2]);
    check_val({tag, ".b2"}, ib2, m_b[2]);
  endtask

  // Inputs change at posedge+1, so they are stable well before the next edge.
  task automatic step(input string tag, input logic rd, input logic we, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic [63:0] wd);
    rd_en = rd; wr_en = we; add_a = a; add_b = b; add_d = d; wdata = wd;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [4:0] ra, rb, rd;
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    add_a = '0; add_b = '0; add_d = '0; wdata = '0;
    model_reset();
    #12;
    check_all("reset_state");
    rst_n = 1'b1;

    // Basic write/read
    step("wr5",   1'b0, 1'b1, 5'd0, 5'd0, 5'd5,  64'hDEAD_BEEF);
    step("wr31",  1'b0, 1'b1, 5'd0, 5'd0, 5'd31, 64'h0000_0011);
    step("rd5_31",1'b1, 1'b0, 5'd5, 5'd31, 5'd0, 64'd0);

    // Async reset between edges after preload
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step("rst_rd5",  1'b1, 1'b0, 5'd5, 5'd31, 5'd0, 64'd0);
    step("rst_rd14", 1'b1, 1'b0, 5'd14, 5'd1, 5'd0, 64'd0);

    // x0 write with simultaneous read, then re-read
    step("x0_wr", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF);
    step("x0_rd", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0);

    // Forwarding
    step("byp_pre", 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 64'h1);
    step("byp_wr",  1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 64'h2);
    step("byp_rd",  1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 64'd0);

    // Stall holds outputs while a write lands
    step("stl_wr",  1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 64'hAA);
    step("stl_rd",  1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 64'd0);
    step("stl_h1",  1'b0, 1'b1, 5'd9, 5'd9, 5'd3, 64'h55);
    step("stl_h2",  1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 64'd0);
    step("stl_h3",  1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 64'd0);
    step("stl_go",  1'b1, 1'b0, 5'd3, 5'd9, 5'd0, 64'd0);

    // Reset overrides a pending write
    step("rmw_pre", 1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 64'd0);
    rd_en = 1'b1; wr_en = 1'b1; add_a = 5'd4; add_b = 5'd4; add_d = 5'd4; wdata = 64'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rmw_fall");
    @(posedge clk);
    #1;
    check_all("rmw_edge");
    #2;
    rst_n = 1'b1;
    step("rmw_rd4", 1'b1, 1'b0, 5'd4, 5'd4, 5'd0, 64'd0);

    // Consecutive writes to one address: last wins
    step("lw1", 1'b0, 1'b1, 5'd0, 5'd0, 5'd12, 64'hAAAA_0001);
    step("lw2", 1'b0, 1'b1, 5'd0, 5'd0, 5'd12, 64'h5555_0002_0000_0003);
    step("lw_rd", 1'b1, 1'b0, 5'd12, 5'd28, 5'd0, 64'd0);

    // Random traffic, biased toward address collisions
    for (int i = 0; i < 600; i++) begin
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rd = 5'd0;
      step("rnd", ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0), ra, rb, rd,
           {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
